// File: rtl/sf48_li_scheduler_if.sv
// sf48_li_scheduler_if: handshake bundle between the interpolator scheduler and its environment
// master : sample source / engine side (drives tick, scaling codes, engine readies, clr_err)
// slave  : the scheduler (drives pass starts, result strobes, latched codes, status)
interface sf48_li_scheduler_if #(parameter int CNT_W = 16);
   logic             sample_tick;
   logic [3:0]       Ks;
   logic [3:0]       Kd;
   logic             ready_LpR;
   logic             ready_LmR;
   logic             clr_err;
   logic             start_LpR;
   logic             start_LmR;
   logic             ready_out_LpR;
   logic             ready_out_LmR;
   logic [3:0]       Ks_act;
   logic [3:0]       Kd_act;
   logic             busy;
   logic             overrun;
   logic             timeout_err;
   logic [CNT_W-1:0] sample_count;
   modport master (
      output sample_tick, Ks, Kd, ready_LpR, ready_LmR, clr_err,
      input  start_LpR, start_LmR, ready_out_LpR, ready_out_LmR, Ks_act, Kd_act,
             busy, overrun, timeout_err, sample_count
   );
   modport slave (
      input  sample_tick, Ks, Kd, ready_LpR, ready_LmR, clr_err,
      output start_LpR, start_LmR, ready_out_LpR, ready_out_LmR, Ks_act, Kd_act,
             busy, overrun, timeout_err, sample_count
   );
endinterface

// File: rtl/sf48_li_scheduler.sv
// sf48_li_scheduler: runs the shared interpolator LpR then LmR once per 48 kHz sample tick
// i_clk  : rising-edge clock
// i_rst  : synchronous active-high reset
// bus    : slave side of sf48_li_scheduler_if
//          in  sample_tick, Ks, Kd, ready_LpR, ready_LmR, clr_err
//          out start_LpR, start_LmR, ready_out_LpR/LmR, Ks_act, Kd_act, busy,
//              overrun, timeout_err, sample_count
module sf48_li_scheduler #(
   parameter int         TIMEOUT = 64,
   parameter logic [3:0] KS_RST  = 4'b1000,
   parameter logic [3:0] KD_RST  = 4'b1100,
   parameter int         CNT_W   = 16
) (
   input logic                i_clk,
   input logic                i_rst,
   sf48_li_scheduler_if.slave bus
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] START_P = 3'd1;
   localparam logic [2:0] WAIT_P  = 3'd2;
   localparam logic [2:0] START_M = 3'd3;
   localparam logic [2:0] WAIT_M  = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;
   localparam int          TW  = $clog2(TIMEOUT);
   localparam logic [TW-1:0] LIM = TW'(TIMEOUT - 1);
   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [TW-1:0]    r_wait;
   logic             r_pend;
   logic             r_ovr;
   logic             r_terr;
   logic [3:0]       r_ks;
   logic [3:0]       r_kd;
   logic [CNT_W-1:0] r_cnt;
   logic             w_in_pass;
   logic             w_wait;
   logic             w_rdy;
   logic             w_to;
   logic             w_load;
   always_comb begin
      w_in_pass = r_state != IDLE && r_state != DONE;
      w_wait    = r_state == WAIT_P || r_state == WAIT_M;
      // only the ready matching the current wait state counts; a ready on the
      // last allowed cycle beats the watchdog
      w_rdy     = r_state == WAIT_P ? bus.ready_LpR : (r_state == WAIT_M && bus.ready_LmR);
      w_to      = w_wait && !w_rdy && r_wait == LIM;
      // a new pass starts from IDLE on a tick, or straight out of DONE when a
      // tick is buffered or arriving
      w_load    = r_state == IDLE ? bus.sample_tick : (r_state == DONE && (r_pend || bus.sample_tick));
      w_next    = w_load              ? START_P
                : r_state == START_P  ? WAIT_P
                : r_state == START_M  ? WAIT_M
                : w_rdy               ? (r_state == WAIT_P ? START_M : DONE)
                : (w_wait && !w_to)   ? r_state
                :                       IDLE;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_wait  <= '0;
         r_pend  <= 1'b0;
         r_ovr   <= 1'b0;
         r_terr  <= 1'b0;
         r_ks    <= KS_RST;
         r_kd    <= KD_RST;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait ? r_wait + 1'b1 : '0;
         if (w_load) begin
            r_ks <= bus.Ks;
            r_kd <= bus.Kd;
         end
         if (r_state == DONE)
            r_cnt <= r_cnt + 1'b1;
         // DONE consumes the buffered tick and re-buffers a coincident one;
         // a watchdog abort discards whatever was buffered
         r_pend  <= w_to             ? 1'b0
                  : r_state == DONE  ? (r_pend && bus.sample_tick)
                  :                    (r_pend || (w_in_pass && bus.sample_tick));
         // set terms are ORed after the clear so a coincident set wins
         r_ovr   <= (w_in_pass && bus.sample_tick && r_pend) || (r_ovr && !bus.clr_err);
         r_terr  <= w_to || (r_terr && !bus.clr_err);
      end
   end
   assign bus.start_LpR     = r_state == START_P;
   assign bus.start_LmR     = r_state == START_M;
   assign bus.ready_out_LpR = r_state == DONE;
   assign bus.ready_out_LmR = r_state == DONE;
   assign bus.busy          = r_state != IDLE;
   assign bus.overrun       = r_ovr;
   assign bus.timeout_err   = r_terr;
   assign bus.Ks_act        = r_ks;
   assign bus.Kd_act        = r_kd;
   assign bus.sample_count  = r_cnt;
endmodule

// File: tb/tb_sf48_li_scheduler.sv
// tb_sf48_li_scheduler: directed scenarios plus a randomized run against a pass-timing model
module tb_sf48_li_scheduler;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int total = 0;
   int bad = 0;
   sf48_li_scheduler_if #(.CNT_W(16)) bus();
   sf48_li_scheduler_if #(.CNT_W(4))  wbus();
   sf48_li_scheduler #(.TIMEOUT(TO), .KS_RST(4'b1000), .KD_RST(4'b1100), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );
   sf48_li_scheduler #(.TIMEOUT(TO), .KS_RST(4'b1000), .KD_RST(4'b1100), .CNT_W(4)) dut_w (
      .i_clk(clk), .i_rst(rst), .bus(wbus)
   );
   logic eng_en = 1'b0;
   logic eng_m_on = 1'b1;
   int   eng_k = 3;
   logic e_rp = 1'b0;
   logic e_rm = 1'b0;
   logic m_rp = 1'b0;
   logic m_rm = 1'b0;
   assign bus.ready_LpR = (eng_en & e_rp) | m_rp;
   assign bus.ready_LmR = (eng_en & e_rm) | m_rm;
   task automatic clk1();
      @(posedge clk);
      #1;
   endtask
   // engine stand-ins: the main one answers a start after eng_k cycles, the
   // wrap-test one answers one cycle after each start
   initial begin : engine
      int cp;
      int cm;
      logic w_ps;
      logic w_pm;
      cp = 0; cm = 0; w_ps = 1'b0; w_pm = 1'b0;
      wbus.ready_LpR = 1'b0;
      wbus.ready_LmR = 1'b0;
      forever begin
         clk1();
         e_rp = 1'b0;
         e_rm = 1'b0;
         if (cp > 0) begin cp--; if (cp == 0) e_rp = 1'b1; end
         if (cm > 0) begin cm--; if (cm == 0) e_rm = eng_m_on; end
         if (bus.start_LpR) cp = eng_k;
         if (bus.start_LmR) cm = eng_k;
         if (rst) begin cp = 0; cm = 0; end
         wbus.ready_LpR = w_ps; w_ps = wbus.start_LpR;
         wbus.ready_LmR = w_pm; w_pm = wbus.start_LmR;
      end
   end
   task automatic do_reset();
      rst = 1'b1;
      bus.sample_tick = 1'b0; bus.clr_err = 1'b0;
      m_rp = 1'b0; m_rm = 1'b0;
      wbus.sample_tick = 1'b0; wbus.Ks = 4'd0; wbus.Kd = 4'd0; wbus.clr_err = 1'b0;
      repeat (2) clk1();
      rst = 1'b0;
   endtask
   task automatic test_reset();
      bus.Ks = 4'b0101; bus.Kd = 4'b0101;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({bus.Ks_act, bus.Kd_act} !== 8'h8C) begin
            bad++; $display("FAIL reset_k i=%0d got=%h exp=8c", i, {bus.Ks_act, bus.Kd_act});
         end
         total++;
         if ({bus.busy, bus.overrun, bus.timeout_err, bus.start_LpR, bus.start_LmR,
              bus.ready_out_LpR, bus.ready_out_LmR} !== 7'b0) begin
            bad++; $display("FAIL reset_flags i=%0d got=%b exp=0", i,
               {bus.busy, bus.overrun, bus.timeout_err, bus.start_LpR, bus.start_LmR,
                bus.ready_out_LpR, bus.ready_out_LmR});
         end
         total++;
         if (bus.sample_count !== 16'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", bus.sample_count);
         end
         clk1();
      end
   endtask
   task automatic test_latency();
      eng_en = 1'b1; eng_k = 3; eng_m_on = 1'b1;
      do_reset();
      bus.Ks = 4'd8; bus.Kd = 4'd12; bus.sample_tick = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         clk1();
         bus.sample_tick = 1'b0;
         total++;
         if ({bus.start_LpR, bus.start_LmR, bus.ready_out_LpR, bus.ready_out_LmR} !==
             {t == 1, t == 5, t == 9, t == 9}) begin
            bad++; $display("FAIL latency t=%0d got=%b exp=%b", t,
               {bus.start_LpR, bus.start_LmR, bus.ready_out_LpR, bus.ready_out_LmR},
               {t == 1, t == 5, t == 9, t == 9});
         end
      end
      total++;
      if ({bus.busy, bus.sample_count} !== {1'b0, 16'd1}) begin
         bad++; $display("FAIL latency_end got busy=%b cnt=%0d exp busy=0 cnt=1", bus.busy, bus.sample_count);
      end
   endtask
   task automatic test_pending_overrun();
      do_reset();
      bus.Ks = 4'd3; bus.Kd = 4'd4; bus.sample_tick = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         clk1();
         bus.sample_tick = (t == 2) || (t == 7);
         total++;
         if ({bus.start_LpR, bus.ready_out_LpR, bus.overrun, bus.busy} !==
             {t == 1 || t == 10, t == 9 || t == 18, t >= 8, t <= 18}) begin
            bad++; $display("FAIL pend t=%0d got=%b exp=%b", t,
               {bus.start_LpR, bus.ready_out_LpR, bus.overrun, bus.busy},
               {t == 1 || t == 10, t == 9 || t == 18, t >= 8, t <= 18});
         end
         total++;
         if (bus.Ks_act !== (t >= 10 ? 4'd9 : 4'd3)) begin
            bad++; $display("FAIL pend_ks t=%0d got=%0d exp=%0d", t, bus.Ks_act, (t >= 10 ? 9 : 3));
         end
         bus.Ks = 4'(t);
      end
      total++;
      if (bus.sample_count !== 16'd2) begin
         bad++; $display("FAIL pend_count got=%0d exp=2", bus.sample_count);
      end
      bus.clr_err = 1'b1;
      clk1();
      bus.clr_err = 1'b0;
      total++;
      if (bus.overrun !== 1'b0) begin
         bad++; $display("FAIL clr_overrun got=%b exp=0", bus.overrun);
      end
   endtask
   task automatic test_timeout();
      do_reset();
      eng_m_on = 1'b0;
      bus.sample_tick = 1'b1;
      for (int t = 1; t <= 72; t++) begin
         clk1();
         bus.sample_tick = 1'b0;
         total++;
         if ({bus.busy, bus.ready_out_LpR | bus.ready_out_LmR, bus.timeout_err} !==
             {t <= 69, 1'b0, t >= 70}) begin
            bad++; $display("FAIL timeout t=%0d got=%b exp=%b", t,
               {bus.busy, bus.ready_out_LpR | bus.ready_out_LmR, bus.timeout_err},
               {t <= 69, 1'b0, t >= 70});
         end
      end
      eng_m_on = 1'b1;
      bus.sample_tick = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         clk1();
         bus.sample_tick = 1'b0;
         total++;
         if ({bus.ready_out_LpR, bus.ready_out_LmR, bus.timeout_err} !== {t == 9, t == 9, 1'b1}) begin
            bad++; $display("FAIL after_timeout t=%0d got=%b exp=%b", t,
               {bus.ready_out_LpR, bus.ready_out_LmR, bus.timeout_err}, {t == 9, t == 9, 1'b1});
         end
      end
      total++;
      if (bus.sample_count !== 16'd1) begin
         bad++; $display("FAIL timeout_count got=%0d exp=1", bus.sample_count);
      end
   endtask
   task automatic test_stray_ready();
      do_reset();
      m_rp = 1'b1; m_rm = 1'b1;
      clk1();
      m_rp = 1'b0; m_rm = 1'b0;
      total++;
      if ({bus.busy, bus.sample_count} !== {1'b0, 16'd0}) begin
         bad++; $display("FAIL stray_idle got busy=%b cnt=%0d exp 0/0", bus.busy, bus.sample_count);
      end
      bus.sample_tick = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         clk1();
         bus.sample_tick = 1'b0;
         total++;
         if ({bus.start_LpR, bus.start_LmR, bus.ready_out_LmR} !== {t == 1, t == 5, t == 9}) begin
            bad++; $display("FAIL stray t=%0d got=%b exp=%b", t,
               {bus.start_LpR, bus.start_LmR, bus.ready_out_LmR}, {t == 1, t == 5, t == 9});
         end
         m_rm = (t <= 3) || (t >= 9);
         m_rp = (t == 1) || (t == 6) || (t == 7) || (t >= 9);
      end
      m_rp = 1'b0; m_rm = 1'b0;
      total++;
      if ({bus.busy, bus.sample_count} !== {1'b0, 16'd1}) begin
         bad++; $display("FAIL stray_end got busy=%b cnt=%0d exp 0/1", bus.busy, bus.sample_count);
      end
   endtask
   task automatic test_reset_mid();
      do_reset();
      bus.Ks = 4'd3; bus.Kd = 4'd5; bus.sample_tick = 1'b1;
      for (int t = 1; t <= 16; t++) begin
         clk1();
         bus.sample_tick = (t == 2);
         rst = (t == 3);
         total++;
         if ({bus.busy, bus.ready_out_LpR, bus.start_LpR, bus.Ks_act, bus.Kd_act} !==
             {t <= 3, 1'b0, t == 1, (t <= 3 ? 4'd3 : 4'd8), (t <= 3 ? 4'd5 : 4'd12)}) begin
            bad++; $display("FAIL reset_mid t=%0d got=%h exp=%h", t,
               {bus.busy, bus.ready_out_LpR, bus.start_LpR, bus.Ks_act, bus.Kd_act},
               {t <= 3, 1'b0, t == 1, (t <= 3 ? 4'd3 : 4'd8), (t <= 3 ? 4'd5 : 4'd12)});
         end
      end
      rst = 1'b0;
   endtask
   task automatic test_wrap();
      int n;
      n = 0;
      do_reset();
      wbus.sample_tick = 1'b1;
      for (int t = 0; t < 100; t++) begin
         clk1();
         total++;
         if (wbus.sample_count !== 4'(n) || wbus.ready_out_LpR !== wbus.ready_out_LmR) begin
            bad++; $display("FAIL wrap t=%0d got=%0d exp=%0d", t, wbus.sample_count, n % 16);
         end
         if (wbus.ready_out_LpR === 1'b1) n++;
      end
      wbus.sample_tick = 1'b0;
      total++;
      if (n < 17) begin
         bad++; $display("FAIL wrap_passes got=%0d exp>=17", n);
      end
   endtask
   function automatic int pick();
      int r;
      r = $urandom_range(0, 19);
      return r == 0 ? TO + 3 : r == 1 ? TO : 1 + r % 4;
   endfunction
   // the model tracks one pass as (start cycle, LpR delay, LmR delay) plus a
   // one-deep tick buffer, and derives every strobe time arithmetically
   task automatic test_random();
      int c, s, kp, km, cnt, endc, wm;
      logic hp, bf, ovr, terr, pf, mf, ok, np, nov, nte, tk, cl, rp, rm, wpw, wmw;
      logic [3:0] ksa, kda, ks, kd;
      logic [30:0] expv, gotv;
      c = 0; s = 0; kp = 0; km = 0; cnt = 0;
      hp = 0; bf = 0; ovr = 0; terr = 0; ksa = 4'd8; kda = 4'd12;
      eng_en = 1'b0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         pf   = kp > TO;
         wm   = s + kp + 2;
         mf   = !pf && km > TO;
         ok   = !pf && !mf;
         endc = pf ? s + TO : mf ? wm + TO - 1 : s + kp + km + 2;
         expv = {hp && c == s, hp && !pf && c == s + kp + 1, hp && ok && c == endc,
                 hp && ok && c == endc, hp, ovr, terr, ksa, kda, 16'(cnt)};
         gotv = {bus.start_LpR, bus.start_LmR, bus.ready_out_LpR, bus.ready_out_LmR, bus.busy,
                 bus.overrun, bus.timeout_err, bus.Ks_act, bus.Kd_act, bus.sample_count};
         total++;
         if (gotv !== expv) begin
            bad++; $display("FAIL random c=%0d got=%h exp=%h", c, gotv, expv);
         end
         wpw = hp && c >= s + 1 && c <= (pf ? s + TO : s + kp);
         wmw = hp && !pf && c >= wm && c <= (mf ? endc : s + kp + 1 + km);
         rp  = (hp && !pf && c == s + kp) || (!wpw && $urandom_range(0, 7) == 0);
         rm  = (hp && ok && c == s + kp + 1 + km) || (!wmw && $urandom_range(0, 7) == 0);
         tk  = $urandom_range(0, 5) == 0;
         cl  = $urandom_range(0, 39) == 0;
         ks  = 4'($urandom);
         kd  = 4'($urandom);
         bus.sample_tick = tk; bus.clr_err = cl; bus.Ks = ks; bus.Kd = kd;
         m_rp = rp; m_rm = rm;
         clk1();
         nov = cl ? 1'b0 : ovr;
         nte = cl ? 1'b0 : terr;
         np  = hp ? (c == endc && ok && (bf || tk)) : tk;
         if (hp && c == endc) begin
            if (ok) begin
               cnt++;
               bf = bf && tk;
            end else begin
               if (tk && bf) nov = 1'b1;
               bf = 1'b0;
               nte = 1'b1;
            end
            hp = 1'b0;
         end else if (hp && tk) begin
            if (bf) nov = 1'b1;
            else bf = 1'b1;
         end
         if (np) begin
            hp = 1'b1; s = c + 1; ksa = ks; kda = kd; kp = pick(); km = pick();
         end
         ovr = nov; terr = nte;
         c++;
      end
      bus.sample_tick = 1'b0; bus.clr_err = 1'b0; m_rp = 1'b0; m_rm = 1'b0;
   endtask
   initial begin
      bus.sample_tick = 1'b0; bus.clr_err = 1'b0; bus.Ks = 4'd0; bus.Kd = 4'd0;
      test_reset();
      test_latency();
      test_pending_overrun();
      test_timeout();
      test_stray_ready();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sf48_li_scheduler.md
Name: sf48_li_scheduler

Overview:
Sequences the shared linear-interpolator engine between the L+R and L-R channels of the 48 kHz stereo front end. For each 48 kHz sample tick it:
- latches the scaling codes Ks and Kd;
- starts the LpR pass, waits for its ready, then does the same for LmR;
- pulses both channel-done flags together.
It also buffers one early tick, flags overruns and recovers from a stalled engine with a watchdog.

Parameters:
TIMEOUT, 64, maximum WAIT cycles allowed for an engine ready (minimum 2)
KS_RST, 4'b1000, Ks_act value after reset
KD_RST, 4'b1100, Kd_act value after reset
CNT_W, 16, width of sample_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
sample_tick  in  1  one-cycle pulse per 48 kHz audio sample
Ks  in  4  sum-path scaling code
Kd  in  4  difference-path scaling code
ready_LpR  in  1  engine finished LpR pass (pulse)
ready_LmR  in  1  engine finished LmR pass (pulse)
clr_err  in  1  clears overrun and timeout_err
start_LpR  out  1  one-cycle start for LpR pass
start_LmR  out  1  one-cycle start for LmR pass
ready_out_LpR  out  1  LpR result valid, one-cycle pulse
ready_out_LmR  out  1  LmR result valid, one-cycle pulse, coincident with ready_out_LpR
Ks_act  out  4  Ks latched for the current sample
Kd_act  out  4  Kd latched for the current sample
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: a tick was dropped
timeout_err  out  1  sticky: the watchdog fired
sample_count  out  CNT_W  completed samples, wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous, active-high, and overrides all other inputs in the same cycle.
  - state = IDLE; all pulses, busy, pending, overrun, timeout_err, wait_cnt and sample_count = 0.
  - Ks_act = KS_RST, Kd_act = KD_RST.
  - Reset mid-operation abandons the pass: no ready_out is issued and any pending tick is discarded.
- States: IDLE, START_P, WAIT_P, START_M, WAIT_M, DONE.
- Outputs are Moore decodes of registered state:
  - start_LpR is high only in START_P; start_LmR is high only in START_M.
  - ready_out_LpR and ready_out_LmR are high only in DONE.
- Transitions:
  - IDLE: sample_tick -> START_P, loading Ks_act<=Ks and Kd_act<=Kd on the same edge.
  - START_P -> WAIT_P, wait_cnt<=0.
  - WAIT_P: ready_LpR -> START_M. Otherwise wait_cnt++; when wait_cnt==TIMEOUT-1 -> IDLE, timeout_err<=1, pending<=0.
  - START_M -> WAIT_M, wait_cnt<=0.
  - WAIT_M: ready_LmR -> DONE. The timeout rule is the same as WAIT_P.
  - DONE: sample_count++. If pending or sample_tick -> START_P, reloading Ks_act/Kd_act and consuming that tick. Otherwise -> IDLE.
- Nominal latency, with tick sampled at edge N and the engine returning ready k cycles after start:
  - start_LpR is high in cycle N+1.
  - ready_out pulses are high in cycle N+2k+3.
- Ready handling:
  - A ready is honoured only in its matching WAIT state.
  - ready_LmR in WAIT_P, ready_LpR in WAIT_M, and any ready in START/IDLE/DONE are ignored with no side effect.
  - ready arriving in the same cycle as the timeout limit counts as success, not a timeout.
- Tick buffering, for a tick while state is not IDLE:
  - In START_x or WAIT_x: if pending=0 then pending<=1. If pending=1 then overrun<=1 and the tick is dropped.
  - In DONE with pending=1: pending is consumed, the new tick sets pending<=1, and no overrun is flagged.
- Ks_act/Kd_act are stable from the START_P cycle through DONE. Changes on Ks/Kd mid-pass have no effect until the next sample.
- clr_err clears overrun and timeout_err on the next edge. If a set event occurs in the same cycle, the set wins.
- sample_count wraps from all-ones to 0 with no flag.

Test Plan:
1. Reset with Ks=4'b0101, then release. Required: Ks_act=4'b1000, Kd_act=4'b1100, busy=0 and all flags 0. Then tick with Ks=8, Kd=12 and an engine returning ready 3 cycles after start. Required: start_LpR at N+1, start_LmR at N+5, both ready_out at N+9, sample_count=1.
2. Second tick two cycles after the first, then a third tick during WAIT_M. Required: the second tick is pending and DONE goes straight to START_P; the third sets overrun=1 and is dropped; sample_count ends at 2. clr_err then clears overrun.
3. Engine never asserts ready_LmR with TIMEOUT=64. Required: WAIT_M is left after 64 cycles, timeout_err=1, no ready_out, busy=0. The next tick processes normally.
4. ready_LmR injected during WAIT_P and ready_LpR during WAIT_M. Required: both are ignored; progress occurs only on the matching ready.
5. Reset asserted in WAIT_P with pending=1. Required: IDLE on the next edge, no ready_out afterwards, pending cleared, Ks_act and Kd_act back to their defaults.
6. Preload sample_count to 16'hFFFF via 65535 fast passes (engine ready after 1 cycle). Required: the next DONE wraps sample_count to 0.
